// File: rtl/ibex_mprf_load_ctrl.sv
// Message-register-file load sequencer: writes a commanded burst of words to consecutive MPRF addresses.
// Latency: zero-cycle write path (word lands on the handshake edge); done_o/err_o pulse one cycle later.
// Backpressure: data_ready_o drops on a same-address core write or on flush; cmd_ready_o only in IDLE.
//
// Optional feature macro: IBEX_MPRF_LOAD_TIMEOUT_EN. When it is defined, a LOAD that sees no data
// handshake for TimeoutCycles cycles is abandoned with an err_o pulse.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/ready_o     load command handshake; cmd_base_i (1..31), cmd_len_i (1..31)
//   data_valid_i/ready_o    message word handshake; data_i is the word
//   core_mprf_we_i          core MPRF write this cycle, to core_waddr_i
//   flush_i                 abort the current load (ignored in IDLE)
//   input_valid_o/addr_o/data_o  MPRF input write port
//   mprf_busy_o             load in progress, ID stage stalls use_mprf reads
//   done_o, err_o           one-cycle completion / error pulses
module ibex_mprf_load_ctrl #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [4:0]           cmd_base_i,
  input  logic [4:0]           cmd_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 core_mprf_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic                 flush_i,
  output logic                 input_valid_o,
  output logic [4:0]           input_addr_o,
  output logic [DataWidth-1:0] input_data_o,
  output logic                 mprf_busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e     state_q;
  logic [4:0] addr_q;
  logic [4:0] rem_q;
  logic       done_q;
  logic       err_q;

  logic       collide;
  logic       data_hs;
  logic       cmd_hs;
  logic       cmd_bad;
  logic [4:0] addr_next;

`ifdef IBEX_MPRF_LOAD_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] tmo_cnt_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TimeoutCycles;
`endif

  // A core write to the address the loader is about to write wins; the loader retries next cycle.
  assign collide      = core_mprf_we_i && (core_waddr_i == addr_q);
  assign data_ready_o = (state_q == LOAD) && !collide && !flush_i;
  assign data_hs      = data_valid_i && data_ready_o;

  assign cmd_ready_o  = (state_q == IDLE);
  assign cmd_hs       = cmd_valid_i && cmd_ready_o;
  assign cmd_bad      = (cmd_base_i == 5'd0) || (cmd_len_i == 5'd0);

  // Address 0 is the hardwired-zero slot, so the wrap goes 31 -> 1.
  assign addr_next    = (addr_q == 5'd31) ? 5'd1 : addr_q + 5'd1;

  assign input_valid_o = data_hs;
  assign input_addr_o  = addr_q;
  assign input_data_o  = data_i;

  assign mprf_busy_o  = (state_q == LOAD);
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= 5'd1;
      rem_q     <= 5'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IBEX_MPRF_LOAD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              addr_q    <= cmd_base_i;
              rem_q     <= cmd_len_i;
              state_q   <= LOAD;
`ifdef IBEX_MPRF_LOAD_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        LOAD: begin
          if (flush_i) begin
            // Flush drops the load silently: no done, no error.
            state_q <= IDLE;
          end else if (data_hs) begin
            rem_q  <= rem_q - 5'd1;
            addr_q <= addr_next;
`ifdef IBEX_MPRF_LOAD_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            if (rem_q == 5'd1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
`ifdef IBEX_MPRF_LOAD_TIMEOUT_EN
          // Collision-stalled cycles count toward the timeout as well.
          else if (tmo_cnt_q == CntMax) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
